// File: rtl/mac_array_ctrl.sv
// Sequences one weight tile then n_act activation rows into mac_array and counts results out.
// Latency: SRAM read issued the cycle after start; inst_w/index_w trail each read by one cycle.
// Backpressure: none; the array is never stalled, and a full output FIFO only raises err.
module mac_array_ctrl #(
    parameter int bw              = 4,
    parameter int psum_bw         = 16,
    parameter int col             = 8,
    parameter int row             = 8,
    parameter int index_selection = 2,
    parameter int act_aw          = 6,
    parameter int settle          = 8,
    parameter int drain_max       = 24
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [act_aw-1:0]              n_act,
    input  logic [row/index_selection-1:0] index_cfg,
    output logic                           wmem_cen,
    output logic [2:0]                     wmem_addr,
    output logic                           amem_cen,
    output logic [act_aw-1:0]              amem_addr,
    output logic [1:0]                     inst_w,
    output logic [row/index_selection-1:0] index_w,
    input  logic [col-1:0]                 valid,
    input  logic                           ofifo_full,
    output logic                           ofifo_wr,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int iw = row / index_selection;
    localparam int cw = 16;

    localparam logic [1:0] INST_IDLE  = 2'b00;
    localparam logic [1:0] INST_LOADW = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b10;

    // Weight address is 3 bits wide, so the tile can be at most 8 columns; the phase
    // counter must also hold the longest settle/drain window.
    if (col < 2 || col > 8 || settle < 1 || drain_max < 1 || iw < 1 ||
        bw < 1 || psum_bw < bw || settle >= (1 << cw) || drain_max >= (1 << cw))
    begin : g_bad_param
        $error("mac_array_ctrl: unsupported parameter combination");
    end

    typedef enum logic [2:0] {IDLE, WLOAD, SETTLE, EXEC, DRAIN} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [cw-1:0]       cnt;
    logic [act_aw-1:0]   n_act_q;
    logic [iw-1:0]       index_q;
    logic [act_aw:0]     out_cnt;
    logic                start_acc;
    logic                exec_last;
    logic                drain_hit;
    logic                drain_to;
    logic                out_beat;
    logic                unused_valid_bits;

    // Only the bottom-right column signals a finished result row.
    assign unused_valid_bits = ^valid[col-2:0];

    assign start_acc = (state == IDLE) && start;
    assign exec_last = (cnt == ({{(cw-act_aw){1'b0}}, n_act_q} - cw'(1)));
    assign drain_hit = (out_cnt == {1'b0, n_act_q});
    assign drain_to  = (cnt == cw'(drain_max - 1));
    assign out_beat  = valid[col-1] && busy;
    assign ofifo_wr  = out_beat;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; phase lengths are measured by cnt, which restarts on every transition
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)                      state_nxt = WLOAD;
            WLOAD:   if (cnt == cw'(col - 1))        state_nxt = SETTLE;
            SETTLE:  if (cnt == cw'(settle - 1))     state_nxt = (n_act_q == '0) ? DRAIN : EXEC;
            EXEC:    if (exec_last)                  state_nxt = DRAIN;
            DRAIN:   if (drain_hit || drain_to)      state_nxt = IDLE;
            default:                                 state_nxt = IDLE;
        endcase
    end

    // Output decode: SRAM strobes and done straight from the current phase
    always_comb begin
        wmem_cen  = 1'b1;
        wmem_addr = '0;
        amem_cen  = 1'b1;
        amem_addr = '0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            WLOAD: begin
                wmem_cen  = 1'b0;
                wmem_addr = cnt[2:0];
            end
            EXEC: begin
                amem_cen  = 1'b0;
                amem_addr = cnt[act_aw-1:0];
            end
            DRAIN:   done = drain_hit || drain_to;
            default: ;
        endcase
    end

    // Phase counter: cleared on entry to each state, held at zero while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                    cnt <= '0;
        else if (state == IDLE || state_nxt != state)  cnt <= '0;
        else                                           cnt <= cnt + cw'(1);
    end

    // Capture the run configuration on an accepted start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_act_q <= '0;
            index_q <= '0;
        end else if (start_acc) begin
            n_act_q <= n_act;
            index_q <= index_cfg;
        end
    end

    // Array command trails the SRAM read by one cycle so it lines up with in_w data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_w  <= INST_IDLE;
            index_w <= '0;
        end else if (state == WLOAD) begin
            inst_w  <= INST_LOADW;
            index_w <= index_q;
        end else if (state == EXEC) begin
            inst_w  <= INST_EXEC;
            index_w <= index_q;
        end else begin
            inst_w  <= INST_IDLE;
            index_w <= '0;
        end
    end

    // Result counter and sticky error (drain timeout or write into a full FIFO)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_cnt <= '0;
            err     <= 1'b0;
        end else if (start_acc) begin
            out_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (out_beat)
                out_cnt <= out_cnt + 1'b1;
            if ((state == DRAIN && drain_to && !drain_hit) || (out_beat && ofifo_full))
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_array_ctrl.sv
module tb_mac_array_ctrl;

    localparam int COL       = 8;
    localparam int SETTLE    = 8;
    localparam int DRAIN_MAX = 24;
    localparam int LAT       = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [5:0] n_act = '0;
    logic [3:0] index_cfg = '0;
    logic       wmem_cen;
    logic [2:0] wmem_addr;
    logic       amem_cen;
    logic [5:0] amem_addr;
    logic [1:0] inst_w;
    logic [3:0] index_w;
    logic [COL-1:0] valid = '0;
    logic       ofifo_full = 1'b0;
    logic       ofifo_wr;
    logic       busy;
    logic       done;
    logic       err;

    mac_array_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .n_act(n_act), .index_cfg(index_cfg),
        .wmem_cen(wmem_cen), .wmem_addr(wmem_addr), .amem_cen(amem_cen), .amem_addr(amem_addr),
        .inst_w(inst_w), .index_w(index_w), .valid(valid), .ofifo_full(ofifo_full),
        .ofifo_wr(ofifo_wr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int cyc;
        int err;
        int wr;
    } done_exp_t;

    int        exp_w[$];
    int        exp_a[$];
    done_exp_t exp_done[$];
    int        sched[$];

    int        ret_limit = 0;
    int        ret_cnt   = 0;
    int        out_idx   = 0;
    int        full_idx  = -1;
    logic [3:0] cur_idx  = '0;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endfunction

    // Array model: each activation read yields one bottom-row result LAT cycles later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            valid = '0;
            valid[COL-2:0] = (COL-1)'($urandom_range(0, 127));
            ofifo_full = 1'b0;
            if (reset) begin
                if (!amem_cen && ret_cnt < ret_limit) begin
                    sched.push_back(cyc + LAT);
                    ret_cnt++;
                end
                if (sched.size() > 0 && sched[0] == cyc) begin
                    void'(sched.pop_front());
                    valid[COL-1] = 1'b1;
                    if (out_idx == full_idx) ofifo_full = 1'b1;
                    out_idx++;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a read, a command or a done.
    initial begin
        int         wr_cnt;
        bit         pw;
        bit         pa;
        bit         pdone;
        int         pend_err;
        int         exp_inst;
        logic [20:0] rv;
        done_exp_t  e;
        wr_cnt = 0; pw = 0; pa = 0; pdone = 0; pend_err = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                rv = {wmem_cen, amem_cen, wmem_addr, amem_addr, inst_w, index_w,
                      ofifo_wr, busy, done, err};
                check("reset_values", int'(rv), int'(21'h18_0000));
                wr_cnt = 0; pw = 0; pa = 0; pdone = 0;
            end else begin
                if (!wmem_cen) begin
                    if (exp_w.size() == 0) check("wmem_read_unexpected", int'(wmem_addr), -1);
                    else                   check("wmem_addr", int'(wmem_addr), exp_w.pop_front());
                end
                if (!amem_cen) begin
                    if (exp_a.size() == 0) check("amem_read_unexpected", int'(amem_addr), -1);
                    else                   check("amem_addr", int'(amem_addr), exp_a.pop_front());
                end
                exp_inst = pw ? 1 : (pa ? 2 : 0);
                if (exp_inst != 0 || inst_w != 2'b00 || index_w != 4'b0000) begin
                    check("inst_w", int'(inst_w), exp_inst);
                    check("index_w", int'(index_w), (exp_inst != 0) ? int'(cur_idx) : 0);
                end
                if (ofifo_wr) wr_cnt++;
                if (pdone) begin
                    check("busy_after_done", int'(busy), 0);
                    check("err_after_done", int'(err), pend_err);
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        check("done_unexpected", cyc, -1);
                    end else begin
                        e = exp_done.pop_front();
                        check("done_cycle", cyc, e.cyc);
                        check("ofifo_wr_count", wr_cnt, e.wr);
                        check("act_reads_left", exp_a.size(), 0);
                        pend_err = e.err;
                    end
                    wr_cnt = 0;
                end
                pw = !wmem_cen;
                pa = !amem_cen;
                pdone = done;
            end
        end
    end

    // Issue one start in the current cycle and queue the hand-computed response.
    task automatic do_start(input int n, input logic [3:0] idx, input int ret, input int fk,
                            input int done_off, input int e_err, input int e_wr);
        done_exp_t e;
        n_act     = 6'(n);
        index_cfg = idx;
        cur_idx   = idx;
        ret_limit = ret;
        ret_cnt   = 0;
        out_idx   = 0;
        full_idx  = fk;
        for (int i = 0; i < COL; i++) exp_w.push_back(i);
        for (int i = 0; i < n; i++)   exp_a.push_back(i);
        e.cyc = cyc + done_off;
        e.err = e_err;
        e.wr  = e_wr;
        exp_done.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) check("done_wait_expired", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit hit;
        // Reset held for 3 cycles with start asserted.
        start = 1'b1;
        idle(3);
        start = 1'b0;
        reset = 1'b1;
        idle(3);

        // Nominal: 8 weight beats, 36 rows; done at 8+8+36+LAT+1 = 63.
        do_start(36, 4'b0101, 36, -1, 63, 0, 36);
        wait_done();
        idle(4);

        // Timeout: 10 rows, 9 results; done at 8+8+10+24 = 50.
        do_start(10, 4'b1010, 9, -1, 50, 1, 9);
        wait_done();
        idle(4);

        // Zero length (also clears the previous err): done at 8+8+1 = 17.
        do_start(0, 4'b0011, 0, -1, 17, 0, 0);
        wait_done();
        idle(4);

        // Overflow on result #5 plus a start pulse mid-EXEC; done at 8+8+20+11 = 47.
        do_start(20, 4'b1100, 20, 5, 47, 1, 20);
        idle(18);
        n_act = 6'd3;
        start = 1'b1;
        idle(1);
        start = 1'b0;
        wait_done();
        idle(4);

        // Reset in the middle of EXEC around address 12.
        do_start(36, 4'b0110, 36, -1, 63, 0, 36);
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            if (!amem_cen && amem_addr == 6'd12) begin
                hit = 1;
                break;
            end
            idle(1);
        end
        if (!hit) check("amem_addr12_wait_expired", 0, 1);
        idle(1);
        reset = 1'b0;
        exp_a.delete();
        exp_done.delete();
        sched.delete();
        ret_limit = 0;
        idle(2);
        reset = 1'b1;
        idle(3);

        // Back-to-back: 5 rows then 63 rows, second start in the cycle after done.
        do_start(5, 4'b1001, 5, -1, 32, 0, 5);
        wait_done();
        idle(1);
        do_start(63, 4'b0101, 63, -1, 90, 0, 63);
        wait_done();
        idle(5);

        check("pending_done", exp_done.size(), 0);
        check("pending_wreads", exp_w.size(), 0);
        check("pending_areads", exp_a.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mac_array_ctrl.md
# mac_array_ctrl

Sequencer for the 8x8 `mac_array` systolic datapath: on `start` it streams one weight tile from weight SRAM into the array (`inst_w=01`), waits for the weights to settle, then streams a programmable number of activation rows (`inst_w=10`). It counts results leaving the bottom of the array, drives the output-FIFO write strobe and reports `done` or `err`. It sits between the SRAM banks and `mac_array`. SRAM read data feeds `in_w` directly, so this block aligns `inst_w` and `index_w` to the 1-cycle SRAM read latency.

## Interface
- `bw`, 4: activation/weight bit width
- `psum_bw`, 16: partial-sum width (documentation only; `in_n` tied to 0 outside this block)
- `col`, 8: array columns = weight beats per tile
- `row`, 8: array rows
- `index_selection`, 2: rows per index bit; `index_w` width = `row/index_selection`
- `act_aw`, 6: activation SRAM address width (max 64 rows)
- `settle`, 8: idle cycles between last weight beat and first activation beat
- `drain_max`, 24: cycles allowed after last activation beat before timeout

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; sampled only in IDLE
- `n_act`  in  act_aw  activation row count, latched on accepted `start`
- `index_cfg`  in  row/index_selection  index pattern, latched on accepted `start`
- `wmem_cen`  out  1  weight SRAM chip enable, active-low
- `wmem_addr`  out  3  weight SRAM address (0..col-1)
- `amem_cen`  out  1  activation SRAM chip enable, active-low
- `amem_addr`  out  act_aw  activation SRAM address
- `inst_w`  out  2  to `mac_array`: 00 idle, 01 load weight, 10 execute
- `index_w`  out  row/index_selection  to `mac_array`
- `valid`  in  col  from `mac_array`
- `ofifo_full`  in  1  output FIFO full
- `ofifo_wr`  out  1  output FIFO write strobe
- `busy`  out  1  high in all states except IDLE
- `done`  out  1  one-cycle pulse on completion
- `err`  out  1  sticky error flag; cleared by the next accepted `start` or by reset

## Operation
- States: IDLE -> WLOAD -> SETTLE -> EXEC -> DRAIN -> IDLE.
- IDLE:
  - `start`=1 latches `n_act` and `index_cfg`, clears `err` and the output counter, and goes to WLOAD.
  - `start` outside IDLE is ignored.
- WLOAD: `col` cycles; `wmem_cen`=0 with `wmem_addr`=0,1,...,col-1; then SETTLE.
- SETTLE:
  - Counts `settle` cycles with both SRAMs disabled.
  - Goes to EXEC, or directly to DRAIN if latched `n_act`=0.
- EXEC: `n_act` cycles; `amem_cen`=0 with `amem_addr`=0..n_act-1; then DRAIN.
- DRAIN:
  - Waits until the output count equals `n_act`, then pulses `done` and returns to IDLE.
  - If `drain_max` cycles elapse first: set `err`, pulse `done`, return to IDLE.
- Command alignment: `inst_w` and `index_w` are registered copies of the previous cycle's read request.
  - Cycle after a weight read: `inst_w`=01, `index_w`=`index_cfg`.
  - Cycle after an activation read: `inst_w`=10, `index_w`=`index_cfg`.
  - Otherwise: `inst_w`=00, `index_w`=0.
- Output count: increments on every cycle with `valid[col-1]`=1 while `busy`. Counter width is `act_aw`+1, so no wrap at 64.
- `ofifo_wr` = `valid[col-1]` & `busy` (combinational).
- If `valid[col-1]` & `ofifo_full`:
  - set `err` (overflow);
  - the write strobe is still asserted;
  - the array is not stalled.
- Extra outputs after the count reaches `n_act` (in the same cycle `done` fires) are ignored.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. An in-flight tile is abandoned; no `done` pulse.

## Timing
- Reset values:
  - `wmem_cen`=1, `amem_cen`=1
  - `wmem_addr`=0, `amem_addr`=0
  - `inst_w`=00, `index_w`=0
  - `ofifo_wr`=0 (`valid` low)
  - `busy`=0, `done`=0, `err`=0
- `start` at cycle T:
  - WLOAD occupies T+1..T+col; first `wmem_cen`=0 at T+1; first `inst_w`=01 at T+2.
  - SETTLE occupies T+col+1..T+col+settle.
  - First `amem_cen`=0 at T+col+settle+1.
- `busy` rises the cycle after an accepted `start` and falls the cycle after `done`.
- Back-to-back: `start` in the cycle after `done` is accepted.

## Test plan
- Reset: assert `reset`=0 for 3 cycles with `start`=1 -> all outputs at reset values, `busy`=0, `wmem_cen` stays 1.
- Nominal:
  - Stimulus: `n_act`=36, `index_cfg`=2'b... (4'b0101); model returns 36 `valid[col-1]` pulses.
  - Required: exactly 8 weight reads, addr 0..7; `inst_w`=01 for 8 cycles, 1 cycle delayed; 36 activation reads, addr 0..35; `index_w`=4'b0101 whenever `inst_w`!=00; one `done`, `err`=0; 36 `ofifo_wr` pulses.
- Zero length: `n_act`=0 -> no activation reads, `done` at T+col+settle+1, `err`=0.
- Timeout: `n_act`=10 with only 9 outputs returned -> `err`=1 and `done` exactly `drain_max` cycles after last activation beat.
- Overflow and ignored start:
  - `ofifo_full`=1 during one output -> `err`=1, `ofifo_wr` still pulses.
  - `start` pulsed during EXEC -> no effect on addresses or counts.
- Mid-run reset and back-to-back:
  - `reset`=0 in EXEC at `amem_addr`=12 -> next cycle IDLE, `amem_cen`=1, no `done`.
  - Then two back-to-back runs -> both complete with correct counts.
